uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//  UART RX companion to the SCI transmitter. Recovers 8N1 frames (LSB first, 1 start bit, 1 stop bit)
//  from the asynchronous iUART_RXD line using a 4x-oversampled baud tick, and presents each byte on a
//  level valid/ack interface to the SCI register block. Reports framing errors and overruns.
//  The block uses a single clock domain. The baud tick is a clock enable, not a derived clock.
// PARAMETERS
//  BAUDRATE_COUNTER  20'd108  (Clock / Baudrate) / 4 - 1; same value as the paired transmitter
// PORTS
//  iCLOCK         in   1  system clock
//  inRESET        in   1  asynchronous reset, active low
//  iRESET_SYNC    in   1  synchronous reset, active high; same effect as inRESET
//  iUART_RXD      in   1  serial input, asynchronous, idle high
//  oRX_VALID      out  1  oRX_DATA holds an unread byte (level)
//  oRX_DATA       out  8  received byte, stable while oRX_VALID=1
//  iRX_ACK        in   1  consumer read; clears oRX_VALID (ignored when oRX_VALID=0)
//  oRX_OVERRUN    out  1  sticky: a byte completed while oRX_VALID=1; cleared by iRX_ACK
//  oRX_FRAME_ERR  out  1  one-cycle pulse: stop bit sampled 0
//  oRX_BUSY       out  1  state != IDLE
// BEHAVIOUR
//  Reset (async or sync): all outputs 0, state IDLE, prescaler 0, synchronizer flops 1.
//  Input: 2-flop synchronizer on iUART_RXD (reset value 1). rxd_s is the 2nd flop, giving 2 clocks of latency.
//  Tick: 20-bit prescaler counts 0..BAUDRATE_COUNTER, then wraps. tick=1 for one clock at wrap.
//    The prescaler is free-running and not restarted on start detect. 4 ticks = 1 bit time.
//  FSM: all transitions are evaluated only on tick=1. sub = 2-bit tick counter, bit = 3-bit index.
//    IDLE : rxd_s=0 -> START, sub<=0.
//    START: at sub==1 (mid start bit): rxd_s=1 -> IDLE (glitch, nothing reported);
//           otherwise -> DATA, sub<=0, bit<=0.
//    DATA : each tick sub++; when sub==3 (4 ticks after the previous sample), shift rxd_s into
//           shreg[7] (shift right, so LSB first). bit==7 at that sample -> STOP, else bit++.
//    STOP : at sub==3: rxd_s=1 -> deliver, then IDLE. rxd_s=0 -> framing error, then BREAK.
//    BREAK: stays until rxd_s=1 on a tick, then IDLE. This avoids re-triggering on a held-low line.
//  Deliver (clock after the stop-bit sample tick):
//    - if oRX_VALID=0, or iRX_ACK=1 in the same cycle: oRX_DATA<=shreg, oRX_VALID<=1.
//    - else the byte is discarded, oRX_OVERRUN<=1, and oRX_DATA/oRX_VALID are unchanged.
//  Framing error: oRX_FRAME_ERR=1 for exactly one clock. The byte is discarded and oRX_VALID is unchanged.
//  iRX_ACK with oRX_VALID=1 and no deliver in that cycle: oRX_VALID<=0 and oRX_OVERRUN<=0 next clock.
//    If an ACK coincides with a deliver, VALID stays 1, new data is loaded, and OVERRUN is cleared.
//  Sampling point: ~2 ticks (mid-bit) after start detect, ±1 tick of jitter from the free-running prescaler.
//  The block returns to IDLE half-way through the stop bit, so back-to-back frames are received with no gap.
//  iRESET_SYNC mid-frame: the partial frame is dropped and there is no FRAME_ERR pulse.
//    Reception resumes on the next falling edge.
// TESTING (BAUDRATE_COUNTER=3 -> 4 clk/tick, 16 clk/bit)
//  1. Drive 8N1 frame 0xA5, bit period 16 clk -> oRX_VALID=1, oRX_DATA=8'hA5, OVERRUN=0, FRAME_ERR=0;
//     iRX_ACK pulse -> VALID=0 next clock.
//  2. Frames 0x3C, 0xC3 back-to-back, no ACK -> DATA=8'h3C kept, OVERRUN=1 after 2nd stop;
//     ACK -> VALID=0, OVERRUN=0.
//  3. Frame 0x55 with stop bit driven 0 for 3 bit times -> single 1-clk FRAME_ERR pulse, VALID stays 0,
//     BUSY=1 until line high; next frame 0x12 received correctly.
//  4. 6-clock low glitch on idle RXD -> BUSY returns 0 after START check, no VALID, no FRAME_ERR.
//  5. ACK asserted exactly in the deliver cycle of a 2nd byte 0x0F with VALID=1 -> VALID stays 1,
//     DATA=8'h0F, OVERRUN=0.
//  6. Pulse iRESET_SYNC during data bit 4 of 0xFF -> all outputs 0; following frame 0x81 received as 8'h81.

Source files
------------

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 4x-oversampled by a free-running baud-tick prescaler.
// Each received byte is held on a level valid/ack interface; the block also flags overruns and framing errors.
module uart_receiver #(
  parameter logic [19:0] BAUDRATE_COUNTER = 20'd108
) (
  input  logic       iCLOCK,
  input  logic       inRESET,
  input  logic       iRESET_SYNC,
  input  logic       iUART_RXD,
  output logic       oRX_VALID,
  output logic [7:0] oRX_DATA,
  input  logic       iRX_ACK,
  output logic       oRX_OVERRUN,
  output logic       oRX_FRAME_ERR,
  output logic       oRX_BUSY
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic        rxd_meta_q, rxd_s_q;
  logic [19:0] presc_q, presc_d;
  logic        tick;
  logic [2:0]  state_q, state_d;
  logic [1:0]  sub_q, sub_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        deliver_q, deliver_d;
  logic        ferr_q, ferr_d;
  logic        valid_q, valid_d;
  logic [7:0]  data_q, data_d;
  logic        ovr_q, ovr_d;

  always_comb begin
    tick    = (presc_q == BAUDRATE_COUNTER);
    presc_d = tick ? 20'd0 : presc_q + 20'd1;
  end

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    sub_d     = sub_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    deliver_d = 1'b0;
    ferr_d    = 1'b0;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rxd_s_q) begin
            state_d = S_START;
            sub_d   = 2'd0;
          end
        end
        S_START: begin
          if (sub_q == 2'd1) begin
            if (rxd_s_q) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DATA;
              sub_d   = 2'd0;
              bit_d   = 3'd0;
            end
          end else begin
            sub_d = sub_q + 2'd1;
          end
        end
        S_DATA: begin
          // sub wraps 3->0, so the first STOP sample lands a full bit time later.
          sub_d = sub_q + 2'd1;
          if (sub_q == 2'd3) begin
            shreg_d = {rxd_s_q, shreg_q[7:1]};
            if (bit_q == 3'd7) state_d = S_STOP;
            else               bit_d   = bit_q + 3'd1;
          end
        end
        S_STOP: begin
          sub_d = sub_q + 2'd1;
          if (sub_q == 2'd3) begin
            if (rxd_s_q) begin
              deliver_d = 1'b1;
              state_d   = S_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (rxd_s_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A coinciding ACK frees the holding register for the new byte and clears any overrun.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovr_d   = ovr_q;
    if (deliver_q) begin
      if (!valid_q || iRX_ACK) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
        if (iRX_ACK) ovr_d = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (iRX_ACK && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      presc_q    <= 20'd0;
      state_q    <= S_IDLE;
      sub_q      <= 2'd0;
      bit_q      <= 3'd0;
      shreg_q    <= 8'd0;
      deliver_q  <= 1'b0;
      ferr_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= 8'd0;
      ovr_q      <= 1'b0;
    end else if (iRESET_SYNC) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      presc_q    <= 20'd0;
      state_q    <= S_IDLE;
      sub_q      <= 2'd0;
      bit_q      <= 3'd0;
      shreg_q    <= 8'd0;
      deliver_q  <= 1'b0;
      ferr_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= 8'd0;
      ovr_q      <= 1'b0;
    end else begin
      rxd_meta_q <= iUART_RXD;
      rxd_s_q    <= rxd_meta_q;
      presc_q    <= presc_d;
      state_q    <= state_d;
      sub_q      <= sub_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      deliver_q  <= deliver_d;
      ferr_q     <= ferr_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      ovr_q      <= ovr_d;
    end
  end

  assign oRX_VALID     = valid_q;
  assign oRX_DATA      = data_q;
  assign oRX_OVERRUN   = ovr_q;
  assign oRX_FRAME_ERR = ferr_q;
  assign oRX_BUSY      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus randomized frames
// compared against a transaction-level model of the valid/ack/overrun/framing rules.
module tb_uart_receiver;

  localparam int BIT_CLK = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rst_sync = 1'b0;
  logic       rxd = 1'b1;
  logic       ack = 1'b0;
  logic       valid, ovr, ferr, busy;
  logic [7:0] data;

  uart_receiver #(.BAUDRATE_COUNTER(20'd3)) dut (
    .iCLOCK       (clk),
    .inRESET      (rst_n),
    .iRESET_SYNC  (rst_sync),
    .iUART_RXD    (rxd),
    .oRX_VALID    (valid),
    .oRX_DATA     (data),
    .iRX_ACK      (ack),
    .oRX_OVERRUN  (ovr),
    .oRX_FRAME_ERR(ferr),
    .oRX_BUSY     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-error pulse monitor: total high cycles and cycles that extend a pulse.
  int   ferr_cycles = 0;
  int   ferr_long   = 0;
  logic ferr_prev   = 1'b0;
  always @(negedge clk) begin
    if (ferr === 1'b1) begin
      ferr_cycles <= ferr_cycles + 1;
      if (ferr_prev === 1'b1) ferr_long <= ferr_long + 1;
    end
    ferr_prev <= ferr;
  end

  // Reference model state (transaction level).
  bit       m_valid = 1'b0;
  bit       m_ovr   = 1'b0;
  bit [7:0] m_data  = 8'd0;
  int       exp_ferr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_deliver(input bit [7:0] b, input bit ack_now);
    if (!m_valid || ack_now) begin
      m_data  = b;
      m_valid = 1'b1;
      if (ack_now) m_ovr = 1'b0;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_data  = 8'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_data(input logic [7:0] b);
    rxd = 1'b0;
    idle(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(BIT_CLK);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    drive_data(b);
    rxd = stop_ok;
    idle(BIT_CLK);
    rxd = 1'b1;
    if (stop_ok) model_deliver(b, 1'b0);
    else         exp_ferr++;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    idle(1);
    ack = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, valid, m_valid);
    check({tag, ".data"},  data,  m_data);
    check({tag, ".ovr"},   ovr,   m_ovr);
    check({tag, ".ferr"},  ferr_cycles, exp_ferr);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit       found;
    bit       busy_seen;
    bit       ok;
    bit [7:0] b;

    idle(3);
    check("rst.valid", valid, 1'b0);
    check("rst.data",  data,  8'd0);
    check("rst.ovr",   ovr,   1'b0);
    check("rst.ferr",  ferr,  1'b0);
    check("rst.busy",  busy,  1'b0);
    rst_n = 1'b1;
    idle(2 * BIT_CLK);

    // 1: single frame, then ACK clears VALID on the next clock
    send_frame(8'hA5, 1'b1);
    idle(2);
    check_all("t1");
    check("t1.busy", busy, 1'b0);
    do_ack();
    check("t1.ack_valid", valid, 1'b0);
    idle(BIT_CLK);

    // 2: back-to-back frames without ACK -> overrun, first byte kept
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    idle(2);
    check_all("t2");
    do_ack();
    check("t2.ack_valid", valid, 1'b0);
    check("t2.ack_ovr",   ovr,   1'b0);
    idle(BIT_CLK);

    // 3: stop bit held low for 3 bit times -> one framing pulse, BREAK until line high
    drive_data(8'h55);
    rxd = 1'b0;
    idle(3 * BIT_CLK);
    exp_ferr++;
    check("t3.busy_break", busy, 1'b1);
    check_all("t3.err");
    rxd = 1'b1;
    idle(BIT_CLK);
    check("t3.busy_idle", busy, 1'b0);
    send_frame(8'h12, 1'b1);
    idle(2);
    check_all("t3.next");
    do_ack();
    idle(BIT_CLK);

    // 4: 6-clock glitch on an idle line
    busy_seen = 1'b0;
    rxd = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (i == 6) rxd = 1'b1;
      idle(1);
      if (busy === 1'b1) busy_seen = 1'b1;
    end
    check("t4.busy_seen", busy_seen, 1'b1);
    check("t4.busy_end",  busy,      1'b0);
    check_all("t4");
    idle(BIT_CLK);

    // 5: ACK in the deliver cycle of a byte arriving while VALID=1 and OVERRUN=1
    send_frame(8'hA0, 1'b1);
    send_frame(8'h33, 1'b1);
    idle(2);
    check_all("t5.pre");
    drive_data(8'h0F);
    rxd = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 32 && !found; i++) begin
      idle(1);
      if (busy === 1'b0) begin
        found = 1'b1;
        ack = 1'b1;
        idle(1);
        ack = 1'b0;
      end
    end
    check("t5.deliver_seen", found, 1'b1);
    model_deliver(8'h0F, 1'b1);
    idle(BIT_CLK);
    check_all("t5");

    // 6: synchronous reset during data bit 4 of 0xFF, then a clean frame
    send_frame(8'h44, 1'b1);
    idle(2);
    check("t6.pre_ovr", ovr, 1'b1);
    rxd = 1'b0;
    idle(BIT_CLK);
    rxd = 1'b1;
    idle(4 * BIT_CLK + BIT_CLK / 2);
    rst_sync = 1'b1;
    idle(1);
    rst_sync = 1'b0;
    model_reset();
    check("t6.busy", busy, 1'b0);
    check("t6.ferr_sig", ferr, 1'b0);
    check_all("t6.rst");
    idle(5 * BIT_CLK);
    check("t6.ferr_none", ferr_cycles, exp_ferr);
    send_frame(8'h81, 1'b1);
    idle(2);
    check_all("t6.next");

    // Randomized frames, stop errors and ACK decisions
    for (int n = 0; n < 24; n++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      send_frame(b, ok);
      idle(2);
      check_all($sformatf("rnd%0d", n));
      if ($urandom_range(0, 1) == 1) begin
        do_ack();
        check($sformatf("rnd%0d.ack", n), valid, m_valid);
      end
      idle(BIT_CLK + $urandom_range(0, 31));
      check($sformatf("rnd%0d.busy", n), busy, 1'b0);
    end

    check("end.ferr_width", ferr_long,   0);
    check("end.ferr_count", ferr_cycles, exp_ferr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
